// File: rtl/tdm_demux_16.sv
// tdm_demux_16: receive end of the 16-channel TDM link.
// Collects one serial bit per qualified slot, framed by a sync pulse on slot 0,
// and presents each completed frame as a parallel word with valid/ready.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   serial_in          channel bit for the current slot
//   bit_valid          serial_in / frame_sync qualifier
//   frame_sync         marks the slot-0 bit (sampled only with bit_valid)
//   data_outputs       last completed frame, bit k = channel k
//   out_valid          data_outputs holds an unconsumed frame
//   out_ready          downstream accepts data_outputs
//   select_line        slot index expected for the next bit
//   sync_error         one-cycle pulse: frame_sync arrived mid-frame
//   overrun            one-cycle pulse: completed frame dropped
module tdm_demux_16 #(
    parameter int unsigned SLOTS = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_sync,
    output logic [SLOTS-1:0] data_outputs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] select_line,
    output logic             sync_error,
    output logic             overrun
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(SLOTS - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    // Slot SLOTS-1 never lands in the shadow: it goes straight into the frame.
    logic [SLOTS-2:0]   shadow_q, shadow_d;
    logic [SLOTS-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               sync_err_q, sync_err_d;
    logic               overrun_q, overrun_d;
    logic               complete_c;
    logic [SLOTS-1:0]   frame_c;

    // Candidate frame if the current bit is the last slot.
    assign frame_c = {serial_in, shadow_q};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            sel_q      <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state: slot tracking, shadow fill, output handshake.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sync_err_d = 1'b0;
        overrun_d  = 1'b0;
        complete_c = 1'b0;

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d    = '0;
                        shadow_d[0] = serial_in;
                        sel_d       = SEL_W'(1);
                        state_d     = RECV;
                    end
                end
                RECV: begin
                    if (frame_sync) begin
                        // Resync: drop the partial frame and restart at slot 1.
                        shadow_d    = '0;
                        shadow_d[0] = serial_in;
                        sel_d       = SEL_W'(1);
                        sync_err_d  = 1'b1;
                    end else if (sel_q == LAST_SLOT) begin
                        complete_c = 1'b1;
                        sel_d      = '0;
                        state_d    = HUNT;
                    end else begin
                        shadow_d[sel_q] = serial_in;
                        sel_d           = sel_q + SEL_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // A completed frame loads only if the output slot is free or draining now.
        if (complete_c) begin
            if (!valid_q || out_ready) begin
                data_d  = frame_c;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign data_outputs = data_q;
    assign out_valid    = valid_q;
    assign select_line  = sel_q;
    assign sync_error   = sync_err_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/tdm_demux_16.md
Name: tdm_demux_16

Overview:
- Receive end of the team's 16-channel time-division link; the transmit end is the 16x1 mux driven by a slot counter.
- Takes a serial bit stream (one bit per slot, framed by a sync pulse on slot 0) and demultiplexes it into 16 parallel channel bits.
- Presents each completed frame as a 16-bit word with a valid/ready handshake to downstream logic.
- Detects mid-frame resync and output overrun.

Parameters:
- SLOTS, 16, number of channel slots per frame (must be a power of 2, 2..16)
- SEL_W, 4, slot index width = log2(SLOTS)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- serial_in  input  1  channel bit for the current slot
- bit_valid  input  1  serial_in/frame_sync qualified this cycle
- frame_sync  input  1  marks the bit of slot 0; sampled only when bit_valid=1
- data_outputs  output  SLOTS  last completed frame; bit k = channel k
- out_valid  output  1  data_outputs holds an unconsumed frame
- out_ready  input  1  downstream accepts data_outputs when out_valid=1
- select_line  output  SEL_W  slot index expected for the next bit (debug/monitor)
- sync_error  output  1  one-cycle pulse: frame_sync arrived mid-frame
- overrun  output  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset (async assert, sync release): state=HUNT, select_line=0, shadow=0, data_outputs=0, out_valid=0, sync_error=0, overrun=0.
- Only cycles with bit_valid=1 are considered. With bit_valid=0, state, select_line and shadow hold.
- HUNT state:
  - bit_valid & frame_sync: shadow[0]=serial_in, select_line=1, go to RECV.
  - bit_valid & !frame_sync: bit ignored, stay in HUNT.
- RECV state, bit_valid & !frame_sync: shadow[select_line]=serial_in, select_line increments.
- Frame completion:
  - On the bit with select_line=SLOTS-1, the frame is complete: {serial_in, shadow[SLOTS-2:0]} is the new frame, select_line wraps to 0, state returns to HUNT.
  - The next frame must start with frame_sync.
- Mid-frame resync, RECV state, bit_valid & frame_sync (select_line != 0):
  - Partial frame discarded; shadow cleared.
  - shadow[0]=serial_in, select_line=1, stay in RECV.
  - sync_error=1 for exactly one cycle.
- Output handshake:
  - Transfer occurs on any edge with out_valid & out_ready.
  - Completion with out_valid=0, or with out_valid=1 & out_ready=1: data_outputs loads the new frame at the same edge and out_valid=1 at the next cycle. Latency is 1 clock from the slot-(SLOTS-1) bit to out_valid.
  - Transfer with no completion in the same cycle: out_valid=0 next cycle; data_outputs holds its value.
  - Completion while out_valid=1 & out_ready=0: the new frame is dropped, data_outputs and out_valid are unchanged, overrun=1 for one cycle.
- data_outputs changes only on frame load or reset; it is never partially updated.
- sync_error and overrun are registered, and are never asserted in the cycle after reset release.
- Reset asserted mid-frame or mid-handshake: immediate return to the reset values; no pending frame survives.
- select_line arithmetic is modulo SLOTS; no other wrap-around exists.

Test Plan:
- Basic frame:
  - Stimulus: reset, then 16 consecutive bit_valid cycles, frame_sync on the first, serial bits = 0xA5C3 LSB-first, out_ready=1.
  - Required: out_valid=1 one cycle after the 16th bit, data_outputs=16'hA5C3, select_line back to 0.
- Gapped input:
  - Stimulus: same frame with bit_valid low every other cycle.
  - Required: same result 16'hA5C3, select_line holds through the gaps.
- Hunt:
  - Stimulus: 5 bit_valid bits without frame_sync, then a valid frame 0x0001.
  - Required: the first 5 bits are ignored, data_outputs=16'h0001.
- Resync:
  - Stimulus: frame_sync at slot 7 of a partial frame, then a full frame 0xFFFF.
  - Required: sync_error pulses once, data_outputs=16'hFFFF, no partial frame is output.
- Backpressure:
  - Stimulus: out_ready=0, two back-to-back frames 0x1234 then 0x5678.
  - Required: overrun pulses at the second completion, data_outputs stays 16'h1234.
  - Stimulus: raise out_ready in the same cycle as a third completion (0x9ABC).
  - Required: 16'h9ABC is loaded, out_valid stays 1.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously at slot 9 of a frame, with out_valid=1 pending.
  - Required: all outputs 0 immediately; after release, a new frame 0x00FF is received correctly.
